// File: rtl/mota_tree_adder.sv
// Pipelined multi-operand binary-tree adder: M unsigned N-bit operands reduced over
// L = log2(M) registered levels. Define TREE_ACC_EN to add the running accumulator stage.
module mota_tree_adder #(
   parameter  int N  = 20,
   parameter  int M  = 8,
   parameter  int G  = 8,
   localparam int L  = $clog2(M),
   localparam int SW = N + L
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic [M*N-1:0]  in_data,
   output logic            out_valid,
   output logic [SW-1:0]   out_sum
`ifdef TREE_ACC_EN
   ,
   input  logic            acc_start,
   output logic            acc_valid,
   output logic [SW+G-1:0] acc_sum
`endif
);

   if (M < 2 || (1 << L) != M || N < 2 || G < 0) begin : g_bad_param
      $error("mota_tree_adder: M must be a power of two >= 2, N >= 2, G >= 0");
   end

   genvar j, i;
   // Level 0 is the raw operand vector; level j holds M>>j partial sums of width N+j.
   for (j = 0; j <= L; j++) begin : g_lvl
      localparam int W = N + j;
      localparam int CNT = M >> j;
      logic [CNT*W-1:0] sum;
      logic             v;
`ifdef TREE_ACC_EN
      logic             st;
`endif
      if (j == 0) begin : g_in
         assign sum = in_data;
         assign v   = in_valid;
`ifdef TREE_ACC_EN
         assign st  = acc_start;
`endif
      end else begin : g_reg
         logic [CNT*W-1:0] nxt;
         for (i = 0; i < CNT; i++) begin : g_add
            assign nxt[i*W +: W] = {1'b0, g_lvl[j-1].sum[(2*i)*(W-1) +: W-1]}
                                 + {1'b0, g_lvl[j-1].sum[(2*i+1)*(W-1) +: W-1]};
         end
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sum <= '0;
               v   <= 1'b0;
`ifdef TREE_ACC_EN
               st  <= 1'b0;
`endif
            end else begin
               v <= g_lvl[j-1].v;
`ifdef TREE_ACC_EN
               st <= g_lvl[j-1].st;
`endif
               if (g_lvl[j-1].v) sum <= nxt;
            end
         end
      end
   end

   assign out_sum   = g_lvl[L].sum;
   assign out_valid = g_lvl[L].v;

`ifdef TREE_ACC_EN
   localparam int AW = SW + G;
   logic [AW-1:0] acc;

   // Wraps modulo 2^AW; a start marker discards the previous total.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         acc_valid <= 1'b0;
      end else begin
         acc_valid <= g_lvl[L].v;
         if (g_lvl[L].v) acc <= (g_lvl[L].st ? '0 : acc) + AW'(g_lvl[L].sum);
      end
   end

   assign acc_sum = acc;
`endif

endmodule

// File: tb/tb_mota_tree_adder.sv
// Scoreboard bench for mota_tree_adder (N=20, M=8); accumulator checks when TREE_ACC_EN is defined.
module tb_mota_tree_adder;
   localparam int N = 20;
   localparam int M = 8;
   localparam int G = 8;
   localparam int L = 3;
   localparam int SW = N + L;
   localparam int AW = SW + G;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic [M*N-1:0]  in_data = '0;
   logic            out_valid;
   logic [SW-1:0]   out_sum;
   logic            acc_start = 1'b0;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   logic [63:0] exp_q[$];
   int          exp_cyc[$];
   logic [63:0] last_sum = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

`ifdef TREE_ACC_EN
   logic            acc_valid;
   logic [AW-1:0]   acc_sum;
   logic [63:0]     acc_q[$];
   int              acc_cyc[$];
   logic [63:0]     acc_m = '0;
   logic [63:0]     last_acc = '0;

   mota_tree_adder #(.N(N), .M(M), .G(G)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .out_valid(out_valid), .out_sum(out_sum),
      .acc_start(acc_start), .acc_valid(acc_valid), .acc_sum(acc_sum));

   logic       in_valid2 = 1'b0;
   logic [3:0] in_data2 = '0;
   logic       acc_start2 = 1'b0;
   logic       out_valid2;
   logic [2:0] out_sum2;
   logic       acc_valid2;
   logic [2:0] acc_sum2;

   mota_tree_adder #(.N(2), .M(2), .G(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_data(in_data2),
      .out_valid(out_valid2), .out_sum(out_sum2),
      .acc_start(acc_start2), .acc_valid(acc_valid2), .acc_sum(acc_sum2));
`else
   mota_tree_adder #(.N(N), .M(M), .G(G)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .out_valid(out_valid), .out_sum(out_sum));
`endif

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] ref_sum(input logic [M*N-1:0] d);
      logic [63:0] s = 0;
      for (int k = 0; k < M; k++) s += 64'(d[k*N +: N]);
      return s;
   endfunction

   // Present one cycle of stimulus; valid vectors enqueue their expected results.
   task automatic issue(input logic v, input logic [M*N-1:0] d, input logic st);
      logic [63:0] s;
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      acc_start = st;
      if (v) begin
         s = ref_sum(d);
         exp_q.push_back(s);
         exp_cyc.push_back(cyc + 1);
`ifdef TREE_ACC_EN
         acc_m = ((st ? 64'd0 : acc_m) + s) & ((64'd1 << AW) - 1);
         acc_q.push_back(acc_m);
         acc_cyc.push_back(cyc + 1);
`endif
      end
   endtask

   function automatic logic [M*N-1:0] one_op(input logic [N-1:0] x);
      logic [M*N-1:0] d = '0;
      d[N-1:0] = x;
      return d;
   endfunction

   // Monitor: pop and compare whenever the DUT presents a result.
   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         if (out_valid) begin
            if (exp_q.size() == 0) chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            else begin
               chk("out_sum", 64'(out_sum), exp_q.pop_front());
               chk("out_latency", 64'(cyc - exp_cyc.pop_front()), 64'(L - 1));
            end
            last_sum = 64'(out_sum);
         end else chk("out_sum_hold", 64'(out_sum), last_sum);
`ifdef TREE_ACC_EN
         if (acc_valid) begin
            if (acc_q.size() == 0) chk("unexpected_acc_valid", 64'(acc_valid), 64'd0);
            else begin
               chk("acc_sum", 64'(acc_sum), acc_q.pop_front());
               chk("acc_latency", 64'(cyc - acc_cyc.pop_front()), 64'(L));
            end
            last_acc = 64'(acc_sum);
         end else chk("acc_sum_hold", 64'(acc_sum), last_acc);
`endif
      end
   end

   initial begin
      logic [M*N-1:0] d;
      #1;
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_out_sum", 64'(out_sum), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // All operands at maximum.
      issue(1'b1, {M{20'hFFFFF}}, 1'b0);
      chk("max_model", ref_sum({M{20'hFFFFF}}), 64'h7FFFF8);
      repeat (5) issue(1'b0, '0, 1'b0);

      // Back-to-back: operands k+1, then all ones.
      for (int k = 0; k < M; k++) d[k*N +: N] = N'(k + 1);
      issue(1'b1, d, 1'b0);
      issue(1'b1, {M{20'd1}}, 1'b0);
      repeat (4) issue(1'b0, '0, 1'b0);

      // Bubble pattern 1,0,1.
      issue(1'b1, one_op(20'd11), 1'b0);
      issue(1'b0, one_op(20'd99), 1'b0);
      issue(1'b1, one_op(20'd22), 1'b0);
      repeat (4) issue(1'b0, '0, 1'b0);

`ifdef TREE_ACC_EN
      issue(1'b1, one_op(20'd100), 1'b1);
      issue(1'b1, one_op(20'd50), 1'b0);
      issue(1'b1, one_op(20'd25), 1'b0);
      issue(1'b1, one_op(20'd7), 1'b1);
      repeat (5) issue(1'b0, '0, 1'b0);
`endif

      // Randomized traffic with random bubbles and start markers.
      for (int t = 0; t < 300; t++) begin
         for (int k = 0; k < M; k++) d[k*N +: N] = N'($urandom);
         issue(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 7) == 0));
      end

      // Reset one cycle after a vector is sampled: it must never emerge.
      issue(1'b1, {M{20'h12345}}, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b0;
      acc_start = 1'b0;
      exp_q.delete();
      exp_cyc.delete();
      last_sum = '0;
`ifdef TREE_ACC_EN
      acc_q.delete();
      acc_cyc.delete();
      acc_m = '0;
      last_acc = '0;
`endif
      #1;
      chk("midreset_out_valid", 64'(out_valid), 64'd0);
      chk("midreset_out_sum", 64'(out_sum), 64'd0);
`ifdef TREE_ACC_EN
      chk("midreset_acc_valid", 64'(acc_valid), 64'd0);
      chk("midreset_acc_sum", 64'(acc_sum), 64'd0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) issue(1'b0, '0, 1'b0);

      // Traffic resumes after reset.
      issue(1'b1, one_op(20'd5), 1'b0);
      issue(1'b1, {M{20'd3}}, 1'b0);
      repeat (6) issue(1'b0, '0, 1'b0);

`ifdef TREE_ACC_EN
      // Narrow instance: accumulator wraps modulo 8.
      fork
         begin
            @(negedge clk);
            in_valid2 = 1'b1; in_data2 = {2'd3, 2'd3}; acc_start2 = 1'b1;
            @(negedge clk);
            acc_start2 = 1'b0;
            @(negedge clk);
            @(negedge clk);
            in_valid2 = 1'b0;
         end
         begin
            logic [2:0] want [3] = '{3'd6, 3'd4, 3'd2};
            for (int k = 0; k < 3; k++) begin
               int t = 0;
               do begin
                  @(posedge clk); #1; t++;
               end while (!acc_valid2 && t < 10);
               if (!acc_valid2) chk("wrap_timeout", 64'd0, 64'd1);
               else chk("wrap_acc_sum", 64'(acc_sum2), 64'(want[k]));
            end
         end
      join
`endif

      begin
         int t = 0;
         while (exp_q.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
         end
      end
      chk("drain_pending", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mota_tree_adder.md
# mota_tree_adder

Pipelined, parametrised multi-operand binary-tree adder: sums M unsigned N-bit operands per cycle through a log2(M)-level tree of two-input ripple-carry adders, with a register bank after every level. It generalises the project's fixed 20-bit two-operand ripple-carry adder into the streaming multi-operand reduction engine of the adder datapath. An optional running accumulator follows the tree.

## Interface
Parameters:
- N, 20, operand width in bits (≥2)
- M, 8, number of operands; power of two, ≥2
- G, 8, accumulator guard bits (used only with TREE_ACC_EN)
- Derived: L = $clog2(M), tree levels; SW = N+L, sum width; AW = SW+G, accumulator width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand vector valid this cycle
- in_data  in  M*N  packed operands; operand k at bits [k*N +: N]
- out_valid  out  1  out_sum valid this cycle
- out_sum  out  SW  unsigned sum of the M operands
- acc_start  in  1  (TREE_ACC_EN only) sampled with in_valid; marks first vector of a new accumulation
- acc_valid  out  1  (TREE_ACC_EN only) acc_sum updated this cycle
- acc_sum  out  AW  (TREE_ACC_EN only) running total

## Operation
- Level j (1..L) holds M/2^j registers of width N+j; register i at level j = reg 2i + reg 2i+1 of level j-1 (level 0 = in_data operands), zero-extended by one bit.
- Each level has a valid bit v[j]; v[1] <= in_valid, v[j] <= v[j-1]. Level j data registers load only when v[j-1] (or in_valid for j=1) is high; otherwise they hold.
- out_sum = the single level-L register; out_valid = v[L].
- Arithmetic unsigned, exact: SW bits always suffice, no overflow at the tree output.
- No backpressure: a new vector may be presented every cycle; bubbles (in_valid low) propagate as bubbles.
- Accumulator (TREE_ACC_EN): acc_start is delayed L cycles alongside v. When v[L] is high: acc <= (start_L ? 0 : acc) + zero-extended out_sum, and acc_valid <= 1; otherwise acc holds, acc_valid <= 0. acc wraps modulo 2^AW.
- First vector after reset without acc_start: accumulates onto 0 (acc reset value).

## Timing
- Reset (async assert, sync-to-clk release): all level registers, valid bits, out_sum, out_valid, acc, acc_valid, delayed acc_start = 0.
- Tree latency: L cycles from in_valid sample edge to out_valid high (M=8: 3 cycles). Throughput 1 vector/cycle.
- Accumulator latency: L+1 cycles from input to acc_valid.
- out_sum/acc_sum hold their last value while their valid is low.
- Reset mid-operation: every in-flight vector discarded; no out_valid for it after rst_n releases.
- Critical path: one ripple adder of width N+L-1 per stage; no combinational path from inputs to outputs.

## Configuration
- Macro TREE_ACC_EN: defined → acc_start, acc_valid, acc_sum ports and the accumulator stage are present, G used. Undefined → those ports and logic absent; block is a pure pipelined tree, G ignored.

## Test plan
- M=8,N=20: single vector, all operands 0xFFFFF → out_valid exactly 3 cycles later, out_sum = 0x7FFFF8; out_valid low otherwise.
- Back-to-back vectors operands k=k+1 (sum 36) then all 1 (sum 8) → out_sum 36 then 8 on consecutive cycles, out_valid high two cycles.
- Bubble pattern in_valid 1,0,1 → out_valid 1,0,1 at latency 3; out_sum held during the bubble.
- rst_n asserted one cycle after a vector is sampled → no out_valid for it; all outputs 0 immediately on assert.
- TREE_ACC_EN: vectors sum 100 (acc_start=1), 50, 25 → acc_sum 100, 150, 175 at cycles 4,5,6; next vector sum 7 with acc_start=1 → acc_sum 7.
- TREE_ACC_EN, G=0, N=2, M=2: repeated sums of 6 → acc_sum 6, 4 (wrap modulo 8), 2.
